// File: rtl/uart_tx_packetizer.sv
// Packetizes one sample per handshake into HEADER, CHAN, MSB, LSB[, CSUM] bytes for the UART TX FIFO.
// Optional checksum byte enabled by defining PACKET_CHECKSUM_EN.
module uart_tx_packetizer #(
    parameter logic [7:0]  HEADER_BYTE = 8'hA5,
    parameter int unsigned CH_W        = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_valid,
    output logic            sample_ready,
    input  logic [CH_W-1:0] sample_channel,
    input  logic [15:0]     sample_data,
    input  logic            full,
    output logic            write_en,
    output logic [7:0]      write_data,
    output logic            busy,
    output logic [15:0]     pkt_count,
    output logic [2:0]      state_dbg
);

    // Handshake: a sample transfers on a rising clk edge when sample_valid && sample_ready;
    // upstream holds channel/data stable until then. FIFO writes occur when write_en is high,
    // and write_en is never raised while full is high.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_CHAN = 3'd2,
        S_MSB  = 3'd3,
`ifdef PACKET_CHECKSUM_EN
        S_LSB  = 3'd4,
        S_CSUM = 3'd5
`else
        S_LSB  = 3'd4
`endif
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CH_W-1:0]   ch_q;
    logic [15:0]       data_q;
    logic [7:0]        chan_byte;
    logic              last_byte;
    logic              accept;

    assign chan_byte    = 8'(ch_q);
    assign sample_ready = (state_q == S_IDLE) && !reset;
    assign busy         = (state_q != S_IDLE);
    assign accept       = sample_valid && sample_ready;
    assign state_dbg    = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            data_q    <= 16'h0000;
            pkt_count <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ch_q   <= sample_channel;
                data_q <= sample_data;
            end
            if (write_en && last_byte) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

    // Each byte state holds until the FIFO takes its byte, so a stall never drops or repeats data.
    always_comb begin
        state_d    = state_q;
        write_en   = 1'b0;
        write_data = 8'h00;
        last_byte  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_HDR;
            end
            S_HDR: begin
                write_en   = !full;
                write_data = HEADER_BYTE;
                if (!full) state_d = S_CHAN;
            end
            S_CHAN: begin
                write_en   = !full;
                write_data = chan_byte;
                if (!full) state_d = S_MSB;
            end
            S_MSB: begin
                write_en   = !full;
                write_data = data_q[15:8];
                if (!full) state_d = S_LSB;
            end
            S_LSB: begin
                write_en   = !full;
                write_data = data_q[7:0];
`ifdef PACKET_CHECKSUM_EN
                if (!full) state_d = S_CSUM;
`else
                last_byte  = 1'b1;
                if (!full) state_d = S_IDLE;
`endif
            end
`ifdef PACKET_CHECKSUM_EN
            S_CSUM: begin
                write_en   = !full;
                write_data = chan_byte ^ data_q[15:8] ^ data_q[7:0];
                last_byte  = 1'b1;
                if (!full) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

endmodule
